// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register file and its write-port logic.
package regfile_pkg;
   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

   localparam int REGFILE_N      = 8;
   localparam int REGFILE_ADDR_W = 5;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. Req[0] is requester A, Req[1] is requester B.
// It owns the priority pointer, which advances only on a grant.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       Clock,
   input  logic       nReset,
   input  logic [1:0] Req,
   input  logic       Enable,
   output logic [1:0] Gnt
);

   pri_t pri_q;
   pri_t pri_d;

   always_comb begin
      Gnt    = 2'b00;
      Gnt[0] = Enable & Req[0] & (~Req[1] | (pri_q == PRI_A));
      Gnt[1] = Enable & Req[1] & (~Req[0] | (pri_q == PRI_B));
      // Nothing is accepted while reset is held, even if requesters are valid.
      if (!nReset) begin
         Gnt = 2'b00;
      end
   end

   always_comb begin
      pri_d = pri_q;
      if (Gnt[0]) begin
         pri_d = PRI_B;
      end else if (Gnt[1]) begin
         pri_d = PRI_A;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         pri_q <= PRI_A;
      end else begin
         pri_q <= pri_d;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU (A) and load return (B)
// paths, registers the winning write and flags read-after-write hazards.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int n          = REGFILE_N,
   parameter int addr_width = REGFILE_ADDR_W
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  Stall,
   input  logic                  AValid,
   input  logic [addr_width-1:0] ARw,
   input  logic [n-1:0]          AData,
   output logic                  AReady,
   input  logic                  BValid,
   input  logic [addr_width-1:0] BRw,
   input  logic [n-1:0]          BData,
   output logic                  BReady,
   output logic                  WE,
   output logic [addr_width-1:0] Rw,
   output logic [n-1:0]          Data,
   input  logic [addr_width-1:0] Rs1,
   input  logic [addr_width-1:0] Rs2,
   output logic                  Hazard1,
   output logic                  Hazard2
);

   logic [1:0]            gnt;
   logic                  we_q, we_d;
   logic [addr_width-1:0] rw_q, rw_d;
   logic [n-1:0]          data_q, data_d;

   rr_arbiter2 u_arb (
      .Clock  (Clock),
      .nReset (nReset),
      .Req    ({BValid, AValid}),
      .Enable (~Stall),
      .Gnt    (gnt)
   );

   assign AReady = gnt[0];
   assign BReady = gnt[1];

   always_comb begin
      we_d   = |gnt;
      rw_d   = rw_q;
      data_d = data_q;
      if (gnt[0]) begin
         rw_d   = ARw;
         data_d = AData;
      end else if (gnt[1]) begin
         rw_d   = BRw;
         data_d = BData;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         we_q   <= 1'b0;
         rw_q   <= '0;
         data_q <= '0;
      end else begin
         we_q   <= we_d;
         rw_q   <= rw_d;
         data_q <= data_d;
      end
   end

   assign WE      = we_q;
   assign Rw      = rw_q;
   assign Data    = data_q;
   assign Hazard1 = we_q && (rw_q == Rs1);
   assign Hazard2 = we_q && (rw_q == Rs2);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file
// that captures on WE, so ordering and aborted writes are visible.
module tb_regfile_write_arbiter;

   logic       Clock = 1'b0;
   logic       nReset, Stall;
   logic       AValid, BValid, AReady, BReady;
   logic [4:0] ARw, BRw, Rw, Rs1, Rs2;
   logic [7:0] AData, BData, Data;
   logic       WE, Hazard1, Hazard2;

   logic [7:0] rf [32] = '{default: 8'h00};

   int compared   = 0;
   int mismatched = 0;

   logic a_pend = 1'b0;
   logic b_pend = 1'b0;

   always #5 Clock = ~Clock;

   regfile_write_arbiter dut (
      .Clock(Clock), .nReset(nReset), .Stall(Stall),
      .AValid(AValid), .ARw(ARw), .AData(AData), .AReady(AReady),
      .BValid(BValid), .BRw(BRw), .BData(BData), .BReady(BReady),
      .WE(WE), .Rw(Rw), .Data(Data),
      .Rs1(Rs1), .Rs2(Rs2), .Hazard1(Hazard1), .Hazard2(Hazard2)
   );

   always @(posedge Clock) begin
      if (WE) rf[Rw] <= Data;
   end

   // Requesters must keep Valid up until accepted.
   always @(posedge Clock) begin
      if (nReset) begin
         if (a_pend && !AValid) begin
            mismatched++;
            $error("FAIL a_valid_withdrawn: observed 0 expected 1");
         end
         if (b_pend && !BValid) begin
            mismatched++;
            $error("FAIL b_valid_withdrawn: observed 0 expected 1");
         end
      end
      a_pend <= nReset && AValid && !AReady;
      b_pend <= nReset && BValid && !BReady;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-16s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] rw, input logic [7:0] d);
      chk({tag, "_we"}, {31'd0, WE}, 32'd1);
      chk({tag, "_rw"}, {27'd0, Rw}, {27'd0, rw});
      chk({tag, "_data"}, {24'd0, Data}, {24'd0, d});
   endtask

   task automatic chk_rdy(input string tag, input logic a, input logic b);
      chk({tag, "_ardy"}, {31'd0, AReady}, {31'd0, a});
      chk({tag, "_brdy"}, {31'd0, BReady}, {31'd0, b});
   endtask

   initial begin
      // Reset with both requesters valid, same destination r7.
      nReset = 1'b0; Stall = 1'b0; Rs1 = 5'd0; Rs2 = 5'd0;
      AValid = 1'b1; ARw = 5'd7; AData = 8'h11;
      BValid = 1'b1; BRw = 5'd7; BData = 8'h22;
      repeat (3) tick();
      chk("rst_we", {31'd0, WE}, 32'd0);
      chk("rst_rw", {27'd0, Rw}, 32'd0);
      chk("rst_data", {24'd0, Data}, 32'd0);
      chk("rst_haz1", {31'd0, Hazard1}, 32'd0);
      chk("rst_haz2", {31'd0, Hazard2}, 32'd0);
      chk_rdy("rst", 1'b0, 1'b0);

      nReset = 1'b1; #1;
      chk_rdy("first", 1'b1, 1'b0);
      tick(); AValid = 1'b0; #1;
      chk_wr("same_a", 5'd7, 8'h11);
      chk_rdy("same_b", 1'b0, 1'b1);
      tick(); BValid = 1'b0; #1;
      chk_wr("same_b", 5'd7, 8'h22);
      tick();
      chk("same_idle_we", {31'd0, WE}, 32'd0);
      chk("r7_final", {24'd0, rf[7]}, 32'h22);

      // Contention: A,B,A,B with fresh data after each acceptance.
      AValid = 1'b1; ARw = 5'd1; AData = 8'hA1;
      BValid = 1'b1; BRw = 5'd4; BData = 8'hB1; #1;
      chk_rdy("ct0", 1'b1, 1'b0);
      tick(); ARw = 5'd2; AData = 8'hA2; #1;
      chk_wr("ct0", 5'd1, 8'hA1);
      chk_rdy("ct1", 1'b0, 1'b1);
      tick(); BRw = 5'd5; BData = 8'hB2; #1;
      chk_wr("ct1", 5'd4, 8'hB1);
      chk_rdy("ct2", 1'b1, 1'b0);
      tick(); AValid = 1'b0; #1;
      chk_wr("ct2", 5'd2, 8'hA2);
      chk_rdy("ct3", 1'b0, 1'b1);
      tick(); BValid = 1'b0; #1;
      chk_wr("ct3", 5'd5, 8'hB2);
      tick();
      chk("ct_idle_we", {31'd0, WE}, 32'd0);

      // Single requester A, one accepted cycle.
      AValid = 1'b1; ARw = 5'd3; AData = 8'h5A; #1;
      chk_rdy("single", 1'b1, 1'b0);
      tick(); AValid = 1'b0; #1;
      chk_wr("single", 5'd3, 8'h5A);
      tick();
      chk("single_idle_we", {31'd0, WE}, 32'd0);

      // Stall: Pri is B here; B wins, then stall with both pending.
      AValid = 1'b1; ARw = 5'd10; AData = 8'hC1;
      BValid = 1'b1; BRw = 5'd11; BData = 8'hC2; #1;
      chk_rdy("pre_stall", 1'b0, 1'b1);
      tick(); Stall = 1'b1; BRw = 5'd12; BData = 8'hC3; #1;
      chk_wr("inflight", 5'd11, 8'hC2);
      chk_rdy("stall0", 1'b0, 1'b0);
      tick();
      chk("stall1_we", {31'd0, WE}, 32'd0);
      chk_rdy("stall1", 1'b0, 1'b0);
      tick();
      chk("stall2_we", {31'd0, WE}, 32'd0);
      chk_rdy("stall2", 1'b0, 1'b0);
      Stall = 1'b0; #1;
      chk_rdy("unstall", 1'b1, 1'b0);
      tick(); AValid = 1'b0; #1;
      chk_wr("post_a", 5'd10, 8'hC1);
      chk_rdy("post_b", 1'b0, 1'b1);
      tick(); BValid = 1'b0; #1;
      chk_wr("post_b", 5'd12, 8'hC3);
      tick();

      // Hazard on r9, then abort the write with reset.
      Rs1 = 5'd9; Rs2 = 5'd4;
      AValid = 1'b1; ARw = 5'd9; AData = 8'h99; #1;
      chk("haz_pre", {31'd0, Hazard1}, 32'd0);
      tick(); AValid = 1'b0; #1;
      chk_wr("haz", 5'd9, 8'h99);
      chk("haz1", {31'd0, Hazard1}, 32'd1);
      chk("haz2", {31'd0, Hazard2}, 32'd0);
      nReset = 1'b0; #1;
      chk("abort_we", {31'd0, WE}, 32'd0);
      chk("abort_haz1", {31'd0, Hazard1}, 32'd0);
      tick();
      chk("r9_kept", {24'd0, rf[9]}, 32'h00);
      chk("r7_kept", {24'd0, rf[7]}, 32'h22);
      chk("r12_written", {24'd0, rf[12]}, 32'hC3);
      nReset = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
